dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/riscv_package.sv | 14 +
 rtl/rr_arbiter2.sv | 23 ++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/riscv_package.sv
// Shared types for the data-memory arbiter: FSM state and read-owner encodings.
package riscv_package;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

endpackage : riscv_package

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick. Purely combinational: the caller keeps the
// "last winner" register and decides when a pick may turn into a grant.
// Bit 0 is the fetch port, bit 1 the data port.
module rr_arbiter2
  import riscv_package::*;
(
  input  logic [1:0] req,
  input  arb_owner_e last,
  output logic [1:0] gnt
);

  // Single requester wins outright; on a tie the port that did not win last time goes.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == OWN_I) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule : rr_arbiter2

// File: rtl/dmem_arbiter.sv
// Shares one fixed-latency memory port between an instruction-fetch port and
// a data port. One read may be outstanding; a new grant is possible when idle
// or in the cycle the outstanding read returns, so reads can stream
// back-to-back. Writes complete in their grant cycle.
module dmem_arbiter
  import riscv_package::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_wr,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          i_stall,
  output logic          d_stall
);

  localparam int            CW       = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  arb_state_e    state_q, state_d;
  arb_owner_e    owner_q, owner_d;
  arb_owner_e    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0] rr_gnt;
  logic       ret;        // outstanding read's data is on m_rdata this cycle
  logic       can_grant;
  logic       gnt_i, gnt_d;
  logic       rd_grant;

  rr_arbiter2 u_rr (
    .req  ({d_req, i_req}),
    .last (last_q),
    .gnt  (rr_gnt)
  );

  assign ret       = (state_q == ARB_BUSY) && (cnt_q == CNT_ONE);
  assign can_grant = (state_q == ARB_IDLE) || ret;
  assign gnt_i     = can_grant & rr_gnt[0];
  assign gnt_d     = can_grant & rr_gnt[1];
  assign rd_grant  = gnt_i | (gnt_d & ~d_wr);

  // State register: FSM state, latency counter, read owner and round-robin history.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_I;
      last_q  <= OWN_D;   // so the first tie after reset goes to fetch
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Next state: count down while busy, (re)load on a read grant, drop to idle on return.
  // NOTE: every variable gets a default at the top of the block, so no path
  // through the branches leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == ARB_BUSY) ? cnt_q - CNT_ONE : cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (rd_grant) begin
      state_d = ARB_BUSY;
      cnt_d   = CNT_LOAD;
      owner_d = gnt_i ? OWN_I : OWN_D;
    end else if (ret) begin
      state_d = ARB_IDLE;
    end
    if (gnt_i) last_d = OWN_I;
    if (gnt_d) last_d = OWN_D;
  end

  // Outputs: grants and memory request from the pick, return data steered to the
  // owner, stalls per port. Everything is forced low while reset is asserted,
  // including the paths that are otherwise combinational from the request inputs.
  always_comb begin
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    m_req    = 1'b0;
    m_wr     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    i_rvalid = 1'b0;
    i_rdata  = '0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    i_stall  = 1'b0;
    d_stall  = 1'b0;
    if (rst_n) begin
      i_gnt = gnt_i;
      d_gnt = gnt_d;
      m_req = gnt_i | gnt_d;
      m_wr  = gnt_d & d_wr;
      if (gnt_d) begin
        m_addr  = d_addr;
        m_wdata = d_wdata;
      end else if (gnt_i) begin
        m_addr = i_addr;
      end
      if (ret && owner_q == OWN_I) begin
        i_rvalid = 1'b1;
        i_rdata  = m_rdata;
      end
      if (ret && owner_q == OWN_D) begin
        d_rvalid = 1'b1;
        d_rdata  = m_rdata;
      end
      i_stall = (i_req & ~gnt_i) |
                ((state_q == ARB_BUSY) && (owner_q == OWN_I) && !ret);
      d_stall = (d_req & ~gnt_d) |
                ((state_q == ARB_BUSY) && (owner_q == OWN_D) && !ret);
    end
  end

endmodule : dmem_arbiter
